fuel_counter: RTL and testbench



---
 rtl/fuel_counter.sv | 67 ++++++
 tb/tb_fuel_counter.sv | 83 ++++++++
 2 files changed

// File: rtl/fuel_counter.sv
// fuel_counter: saturating dispensed-fuel accumulator with prescaler; optional FUEL_COUNTER_AUTOCLEAR_EN restarts count on each new session
module fuel_counter #(
  parameter int WIDTH = 8,
  parameter int MAX_AMOUNT = 255,
  parameter int TICKS_PER_UNIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] fuel_amount,
  output logic             pumping,
  output logic             full
);
  localparam int PW = TICKS_PER_UNIT > 1 ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICKS_PER_UNIT - 1);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_AMOUNT);
  typedef enum logic [1:0] {IDLE, PUMPING, PAUSED, FULL} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] psc, psc_nxt;
  logic [WIDTH-1:0] amount_nxt;
  logic run, tick, inc, hit, clr;
`ifdef FUEL_COUNTER_AUTOCLEAR_EN
  logic start_q;
  // previous start level; tracked through reset so a start held across reset is not a new session
  always_ff @(posedge clk) start_q <= start;
  assign clr = start && !start_q && !stop && (state == IDLE || state == FULL);
`else
  assign clr = 1'b0;
`endif
  assign run = start && !stop && state != FULL;
  assign tick = run && psc == LAST;
  assign inc = tick && !clr && fuel_amount != MAX;
  assign hit = inc && fuel_amount == MAX - WIDTH'(1);
  assign amount_nxt = clr ? '0 : inc ? fuel_amount + WIDTH'(1) : fuel_amount;
  // prescaler holds on stop, clears when start drops, wraps on the unit tick
  assign psc_nxt = clr ? '0 : stop ? psc : !start ? '0 : state == FULL ? psc : tick ? '0 : psc + PW'(1);
  // state, prescaler and count registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      psc <= '0;
      fuel_amount <= '0;
    end else begin
      state <= state_nxt;
      psc <= psc_nxt;
      fuel_amount <= amount_nxt;
    end
  end
  // next state: stop beats start; the edge writing MAX_AMOUNT lands in FULL
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start && !stop ? PUMPING : IDLE;
      PUMPING: state_nxt = stop ? PAUSED : !start ? IDLE : PUMPING;
      PAUSED:  state_nxt = stop ? PAUSED : start ? PUMPING : IDLE;
      default: state_nxt = FULL;
    endcase
    if (hit) state_nxt = FULL;
    if (clr) state_nxt = PUMPING;
  end
  // Moore outputs decoded from the registered state
  always_comb begin
    pumping = state == PUMPING;
    full = state == FULL;
  end
endmodule

// File: tb/tb_fuel_counter.sv
// tb_fuel_counter: scoreboard bench driving default, MAX_AMOUNT=10 and TICKS_PER_UNIT=4 instances in lockstep
module tb_fuel_counter;
  typedef struct {int d; int amt; bit p; bit f; int n;} exp_t;
  logic clk = 0, reset, start, stop, done = 0;
  logic [7:0] a0, a1, a2;
  logic p0, p1, p2, f0, f1, f2;
  exp_t q[$];
  int errors = 0, checks = 0, stepn = 0;
  fuel_counter u0 (.clk(clk), .reset(reset), .start(start), .stop(stop), .fuel_amount(a0), .pumping(p0), .full(f0));
  fuel_counter #(.MAX_AMOUNT(10)) u1 (.clk(clk), .reset(reset), .start(start), .stop(stop), .fuel_amount(a1), .pumping(p1), .full(f1));
  fuel_counter #(.TICKS_PER_UNIT(4)) u2 (.clk(clk), .reset(reset), .start(start), .stop(stop), .fuel_amount(a2), .pumping(p2), .full(f2));
  always #5 clk = ~clk;
  task automatic step(input bit r, s, sp, input int e0, input bit ep0, ef0, input int e1, input bit ep1, ef1, input int e2, input bit ep2, ef2);
    reset = r;
    start = s;
    stop = sp;
    q.push_back('{0, e0, ep0, ef0, stepn});
    q.push_back('{1, e1, ep1, ef1, stepn});
    q.push_back('{2, e2, ep2, ef2, stepn});
    stepn++;
    @(negedge clk);
  endtask
  initial begin
    step(1,0,0, 0,0,0, 0,0,0, 0,0,0);
    step(0,0,0, 0,0,0, 0,0,0, 0,0,0);
    step(0,1,0, 1,1,0, 1,1,0, 0,1,0);
    step(0,1,0, 2,1,0, 2,1,0, 0,1,0);
    step(0,1,0, 3,1,0, 3,1,0, 0,1,0);
    step(0,1,0, 4,1,0, 4,1,0, 1,1,0);
    step(0,1,0, 5,1,0, 5,1,0, 1,1,0);
    step(0,1,1, 5,0,0, 5,0,0, 1,0,0);
    step(0,1,1, 5,0,0, 5,0,0, 1,0,0);
    step(0,1,0, 6,1,0, 6,1,0, 1,1,0);
    step(0,1,0, 7,1,0, 7,1,0, 1,1,0);
    step(0,1,0, 8,1,0, 8,1,0, 2,1,0);
    step(0,0,0, 8,0,0, 8,0,0, 2,0,0);
    step(0,0,0, 8,0,0, 8,0,0, 2,0,0);
    for (int k = 1; k <= 20; k++)
      step(0,1,0, 8+k,1,0, k >= 2 ? 10 : 9, k < 2, k >= 2, 2+k/4,1,0);
    step(0,1,1, 28,0,0, 10,0,1, 7,0,0);
    step(0,0,0, 28,0,0, 10,0,1, 7,0,0);
    step(0,1,0, 29,1,0, 10,0,1, 7,1,0);
    step(0,1,0, 30,1,0, 10,0,1, 7,1,0);
    step(0,1,1, 30,0,0, 10,0,1, 7,0,0);
    step(0,1,0, 31,1,0, 10,0,1, 7,1,0);
    step(0,1,0, 32,1,0, 10,0,1, 8,1,0);
    step(1,1,0, 0,0,0, 0,0,0, 0,0,0);
    for (int k = 1; k <= 6; k++)
      step(0,1,0, k,1,0, k,1,0, k/4,1,0);
    step(1,1,0, 0,0,0, 0,0,0, 0,0,0);
    step(0,1,0, 1,1,0, 1,1,0, 0,1,0);
    step(0,1,0, 2,1,0, 2,1,0, 0,1,0);
    done = 1;
  end
  initial begin
    exp_t e;
    int a;
    bit p, f;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        a = e.d == 0 ? int'(a0) : e.d == 1 ? int'(a1) : int'(a2);
        p = e.d == 0 ? p0 : e.d == 1 ? p1 : p2;
        f = e.d == 0 ? f0 : e.d == 1 ? f1 : f2;
        checks++;
        if (a != e.amt || p != e.p || f != e.f) begin
          errors++;
          $display("FAIL step%0d dut%0d: got amt=%0d pumping=%0b full=%0b, want amt=%0d pumping=%0b full=%0b", e.n, e.d, a, p, f, e.amt, e.p, e.f);
        end
      end
      if (done) begin
        if (q.size() != 0) begin
          errors++;
          $display("FAIL leftover: got %0d unchecked entries, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end
endmodule
